// File: rtl/rf_mp_if.sv
// rf_mp_if: bundles the write, read, clear and debug-scan signals of rf_mp.
// The master side drives write/read addresses and controls; the slave side
// (the register file) returns read data, busy and the debug-scan outputs.
// clr_state mirrors the clear FSM state (0 = IDLE, 1 = CLEAR) for observation.
// Write ports have no handshake: with weN high a write is taken at the next
// rising edge, unless busy is high, in which case it is dropped.
interface rf_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we0;
    logic [ADDR_W-1:0] wa0;
    logic [DATA_W-1:0] wd0;
    logic              we1;
    logic [ADDR_W-1:0] wa1;
    logic [DATA_W-1:0] wd1;
    logic [ADDR_W-1:0] ra0;
    logic [DATA_W-1:0] rd0;
    logic [ADDR_W-1:0] ra1;
    logic [DATA_W-1:0] rd1;
    logic              clr_req;
    logic              busy;
    logic              dbg_en;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic              clr_state;

    modport master (
        output we0, wa0, wd0, we1, wa1, wd1, ra0, ra1, clr_req, dbg_en,
        input  rd0, rd1, busy, dbg_addr, dbg_data, clr_state
    );

    modport slave (
        input  we0, wa0, wd0, we1, wa1, wd1, ra0, ra1, clr_req, dbg_en,
        output rd0, rd1, busy, dbg_addr, dbg_data, clr_state
    );
endinterface

// File: rtl/rf_mp.sv
// rf_mp: two-write / two-read register file with hardwired zero register,
// sequential bulk-clear engine and an auto-scanning debug read port.
// Optional feature macro: RF_BYPASS_EN -- forwards same-cycle write data onto
// rd0/rd1 (port 1 has priority); dbg_data is never bypassed.
module rf_mp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int DBG_DIV = 4
) (
    input logic   clk,
    input logic   rstn,
    rf_mp_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int DIV_W = (DBG_DIV > 1) ? $clog2(DBG_DIV) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DIV_W-1:0]  div;
    logic [ADDR_W-1:0] dbg_addr_q;
    logic [DATA_W-1:0] stored0;
    logic [DATA_W-1:0] stored1;

    // Clear FSM state and clear counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Clear FSM next state: sweep registers 1..DEPTH-1, one per edge.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (bus.clr_req) begin
                    state_nx = CLEAR;
                    cnt_nx   = ADDR_W'(1);
                end
            end
            CLEAR: begin
                cnt_nx = cnt + 1'b1;
                if (cnt == ADDR_W'(DEPTH - 1)) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Storage: clear sweep has precedence; port writes only while idle, port 1 wins.
    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (state == CLEAR) begin
                    if (cnt == ADDR_W'(i)) begin
                        mem[i] <= '0;
                    end
                end else if (bus.we1 && (bus.wa1 == ADDR_W'(i))) begin
                    mem[i] <= bus.wd1;
                end else if (bus.we0 && (bus.wa0 == ADDR_W'(i))) begin
                    mem[i] <= bus.wd0;
                end
            end
        end
    end

    // Debug scan: divider wraps every DBG_DIV enabled cycles and steps the address.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div        <= '0;
            dbg_addr_q <= '0;
        end else if (bus.dbg_en) begin
            if (div == DIV_W'(DBG_DIV - 1)) begin
                div        <= '0;
                dbg_addr_q <= dbg_addr_q + 1'b1;
            end else begin
                div <= div + 1'b1;
            end
        end
    end

    assign stored0 = (bus.ra0 == '0) ? '0 : mem[bus.ra0];
    assign stored1 = (bus.ra1 == '0) ? '0 : mem[bus.ra1];

`ifdef RF_BYPASS_EN
    // Read port 0 with same-cycle forwarding of an accepted write.
    always_comb begin
        bus.rd0 = stored0;
        if ((state == IDLE) && (bus.ra0 != '0)) begin
            if (bus.we1 && (bus.wa1 == bus.ra0)) begin
                bus.rd0 = bus.wd1;
            end else if (bus.we0 && (bus.wa0 == bus.ra0)) begin
                bus.rd0 = bus.wd0;
            end
        end
    end

    // Read port 1 with same-cycle forwarding of an accepted write.
    always_comb begin
        bus.rd1 = stored1;
        if ((state == IDLE) && (bus.ra1 != '0)) begin
            if (bus.we1 && (bus.wa1 == bus.ra1)) begin
                bus.rd1 = bus.wd1;
            end else if (bus.we0 && (bus.wa0 == bus.ra1)) begin
                bus.rd1 = bus.wd0;
            end
        end
    end
`else
    assign bus.rd0 = stored0;
    assign bus.rd1 = stored1;
`endif

    assign bus.busy      = (state == CLEAR);
    assign bus.clr_state = state;
    assign bus.dbg_addr  = dbg_addr_q;
    assign bus.dbg_data  = (dbg_addr_q == '0) ? '0 : mem[dbg_addr_q];
endmodule

// File: tb/tb_rf_mp.sv
// tb_rf_mp: randomized and directed stimulus for rf_mp, checked by a
// scoreboard against a behavioural register-file model kept in the bench.
module tb_rf_mp;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int DBG_DIV = 4;
    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int W       = 3 * DATA_W + 1 + ADDR_W;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    rf_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rf_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DBG_DIV(DBG_DIV)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    logic         chk     = 1'b0;

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                busy_left;   // cycles of clearing still to come
    int                dbg_cnt;     // enabled cycles since reset

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        busy_left = 0;
        dbg_cnt   = 0;
    endfunction

    function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = ref_mem[a];
`ifdef RF_BYPASS_EN
        if (busy_left == 0 && a != '0) begin
            if (bus.we1 && bus.wa1 == a) v = bus.wd1;
            else if (bus.we0 && bus.wa0 == a) v = bus.wd0;
        end
`endif
        return v;
    endfunction

    function automatic logic [W-1:0] exp_vec();
        logic [ADDR_W-1:0] da;
        logic              eb;
        da = ADDR_W'((dbg_cnt / DBG_DIV) % DEPTH);
        eb = (busy_left > 0);
        return {ref_read(bus.ra0), ref_read(bus.ra1), eb, da, ref_mem[da]};
    endfunction

    // Effect of one rising edge on the model.
    function automatic void model_tick();
        if (busy_left > 0) begin
            ref_mem[DEPTH - busy_left] = '0;
            busy_left--;
        end else begin
            if (bus.we0 && bus.wa0 != '0) ref_mem[bus.wa0] = bus.wd0;
            if (bus.we1 && bus.wa1 != '0) ref_mem[bus.wa1] = bus.wd1;
            if (bus.clr_req) busy_left = DEPTH - 1;
        end
        if (bus.dbg_en) dbg_cnt++;
    endfunction

    // ---------------- driver ----------------
    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic step(input bit check, input string nm);
        if (!rstn) model_reset();
        if (check) begin
            exp_q.push_back(exp_vec());
            name_q.push_back(nm);
        end
        chk = check;
        @(posedge clk);
        if (rstn) model_tick();
        @(negedge clk);
        chk = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.we0 = 1'b0; bus.wa0 = '0; bus.wd0 = '0;
        bus.we1 = 1'b0; bus.wa1 = '0; bus.wd1 = '0;
        bus.ra0 = '0;   bus.ra1 = '0;
        bus.clr_req = 1'b0;
        bus.dbg_en  = 1'b0;
    endtask

    // ---------------- monitor ----------------
    always begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        string        nm;
        @(negedge clk);
        #3;
        if (chk) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard: no expected entry queued");
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = {bus.rd0, bus.rd1, bus.busy, bus.dbg_addr, bus.dbg_data};
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s: got rd0=%h rd1=%h busy=%b dbg_addr=%0d dbg_data=%h, want rd0=%h rd1=%h busy=%b dbg_addr=%0d dbg_data=%h",
                             nm, a[W-1 -: DATA_W], a[W-DATA_W-1 -: DATA_W], a[DATA_W+ADDR_W],
                             a[DATA_W +: ADDR_W], a[DATA_W-1:0],
                             e[W-1 -: DATA_W], e[W-DATA_W-1 -: DATA_W], e[DATA_W+ADDR_W],
                             e[DATA_W +: ADDR_W], e[DATA_W-1:0]);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int busy_cycles;
        idle_inputs();
        model_reset();
        @(negedge clk);
        step(1, "reset");
        step(1, "reset_hold");
        rstn = 1'b1;

        // single write then read back
        bus.we0 = 1'b1; bus.wa0 = 5'd3; bus.wd0 = 32'hDEADBEEF;
        step(1, "wr3");
        bus.we0 = 1'b0; bus.ra0 = 5'd3; bus.ra1 = 5'd0;
        step(1, "rd3");

        // same-address dual write, port 1 wins
        bus.we0 = 1'b1; bus.wa0 = 5'd7; bus.wd0 = 32'h11;
        bus.we1 = 1'b1; bus.wa1 = 5'd7; bus.wd1 = 32'h22;
        step(0, "");
        bus.we0 = 1'b0; bus.we1 = 1'b0; bus.ra0 = 5'd7;
        step(1, "dual_wr7");

        // write to register 0 is dropped
        bus.we1 = 1'b1; bus.wa1 = 5'd0; bus.wd1 = 32'hFFFFFFFF; bus.ra0 = 5'd0;
        step(1, "wr0_same");
        bus.we1 = 1'b0;
        step(1, "wr0_after");

        // same-cycle read of an in-flight write
        bus.we0 = 1'b1; bus.wa0 = 5'd9; bus.wd0 = 32'h77;
        step(0, "");
        bus.wd0 = 32'h55; bus.ra1 = 5'd9;
        step(1, "byp_same");
        bus.we0 = 1'b0;
        step(1, "byp_next");

        // fill 1..31 with nonzero data
        for (int i = 1; i < DEPTH; i++) begin
            bus.we0 = 1'b1; bus.wa0 = ADDR_W'(i); bus.wd0 = $urandom | 32'h1;
            bus.ra0 = ADDR_W'(i); bus.ra1 = ADDR_W'($urandom_range(0, DEPTH - 1));
            step(1, "fill");
        end
        bus.we0 = 1'b0;

        // bulk clear with a dropped write in the middle
        bus.clr_req = 1'b1;
        step(1, "clr_pulse");
        bus.clr_req = 1'b0;
        busy_cycles = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.busy) busy_cycles++;
            if (k == 4) begin
                bus.we0 = 1'b1; bus.wa0 = 5'd5; bus.wd0 = 32'hAB;
            end else begin
                bus.we0 = 1'b0;
            end
            bus.ra0 = 5'd5; bus.ra1 = ADDR_W'($urandom_range(0, DEPTH - 1));
            step(1, "clear_run");
        end
        n_tests++;
        if (busy_cycles != DEPTH - 1) begin
            n_fail++;
            $display("FAIL busy_len: got %0d cycles, want %0d", busy_cycles, DEPTH - 1);
        end
        bus.we0 = 1'b0;
        for (int i = 0; i < DEPTH; i += 2) begin
            bus.ra0 = ADDR_W'(i); bus.ra1 = ADDR_W'(i + 1);
            step(1, "post_clear");
        end

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            bus.we0 = 1'($urandom_range(0, 1));
            bus.wa0 = ADDR_W'($urandom_range(0, DEPTH - 1));
            bus.wd0 = $urandom;
            bus.we1 = 1'($urandom_range(0, 1));
            bus.wa1 = ($urandom_range(0, 3) == 0) ? bus.wa0 : ADDR_W'($urandom_range(0, DEPTH - 1));
            bus.wd1 = $urandom;
            bus.ra0 = ($urandom_range(0, 2) == 0) ? bus.wa0 : ADDR_W'($urandom_range(0, DEPTH - 1));
            bus.ra1 = ($urandom_range(0, 2) == 0) ? bus.wa1 : ADDR_W'($urandom_range(0, DEPTH - 1));
            bus.clr_req = ($urandom_range(0, 39) == 0);
            bus.dbg_en  = 1'($urandom_range(0, 1));
            step(1, "random");
        end

        // debug scan from reset
        idle_inputs();
        rstn = 1'b0;
        step(1, "rst_dbg");
        rstn = 1'b1;
        bus.dbg_en = 1'b1;
        for (int c = 0; c < 9; c++) begin
            bus.ra0 = ADDR_W'(c);
            step(1, "dbg_scan");
        end
        bus.dbg_en = 1'b0;
        for (int c = 0; c < 5; c++) step(1, "dbg_hold");

        // reset in the middle of a clear
        for (int i = 1; i < DEPTH; i++) begin
            bus.we1 = 1'b1; bus.wa1 = ADDR_W'(i); bus.wd1 = $urandom | 32'h100;
            step(0, "");
        end
        bus.we1 = 1'b0;
        bus.clr_req = 1'b1;
        step(1, "clr_pulse2");
        bus.clr_req = 1'b0;
        for (int c = 0; c < 10; c++) begin
            bus.ra0 = 5'd20; bus.ra1 = ADDR_W'(c);
            step(1, "clear_run2");
        end
        rstn = 1'b0;
        bus.ra0 = 5'd25; bus.ra1 = 5'd31;
        step(1, "rst_mid_clear");
        bus.ra0 = 5'd12; bus.ra1 = 5'd18;
        step(1, "rst_mid_clear_hold");
        rstn = 1'b1;
        bus.ra0 = 5'd30; bus.ra1 = 5'd2;
        step(1, "after_rst");

        @(negedge clk);
        #5;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected entries never checked", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_mp.md
# rf_mp

Parametrised multi-port register file, successor to the CPU's single-write register file. It provides two write ports and two asynchronous read ports, with a hardwired zero register. A sequential bulk-clear engine reports a busy flag. An auto-scanning debug read port steps through every register for the board display. It sits in the decode/writeback stage of the single-cycle core and is sized by parameters for wider or deeper variants.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- DBG_DIV, 4, clock cycles per debug-scan step (≥1)

- clk  in  1  clock, all state updates on rising edge
- rstn  in  1  reset; one clock, reset is asynchronous and active-low
- we0  in  1  write enable, port 0
- wa0  in  ADDR_W  write address, port 0
- wd0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1
- wa1  in  ADDR_W  write address, port 1
- wd1  in  DATA_W  write data, port 1
- ra0  in  ADDR_W  read address, port 0
- rd0  out  DATA_W  read data, port 0 (combinational)
- ra1  in  ADDR_W  read address, port 1
- rd1  out  DATA_W  read data, port 1 (combinational)
- clr_req  in  1  bulk-clear request, sampled on the clock edge
- busy  out  1  registered; high while a bulk clear runs
- dbg_en  in  1  debug scan enable
- dbg_addr  out  ADDR_W  registered; current scan address
- dbg_data  out  DATA_W  contents at dbg_addr (combinational)

## Operation
- Reset (rstn=0, asynchronous):
  - all registers are 0; FSM is IDLE; busy=0; clear counter is 0; divider is 0; dbg_addr=0.
  - As a result rd0/rd1/dbg_data read 0.
- Register 0:
  - always reads 0;
  - writes addressed to 0 are dropped on either port.
- Writes:
  - on the edge, with enable high, wdN is stored at waN.
  - If we0 and we1 are both high with wa0==wa1, port 1 wins.
  - Writes to different addresses both commit.
- Reads: rdN = array[raN], combinational; no read-side latency.
- Clear FSM has two states, IDLE and CLEAR.
  - IDLE: when clr_req=1 at an edge, the FSM goes to CLEAR, the counter is set to 1 and busy goes to 1.
  - CLEAR: at each edge, array[counter] is set to 0 and the counter increments.
  - When the counter equals DEPTH-1, that register is cleared and the FSM returns to IDLE with busy=0.
  - Port writes (we0/we1) are ignored for the whole time busy=1.
  - clr_req is ignored while in CLEAR.
  - Reads during CLEAR return the current, partially cleared contents.
- Debug scan:
  - While dbg_en=1, the divider counts 0..DBG_DIV-1.
  - On the wrap edge, dbg_addr increments modulo DEPTH (DEPTH-1 wraps to 0).
  - While dbg_en=0, the divider and dbg_addr hold their values.
  - dbg_data = array[dbg_addr], with register 0 reading 0.

## Timing
- Write at edge N is visible on rdN/dbg_data after edge N (same-cycle forwarding only with RF_BYPASS_EN).
- clr_req sampled at edge N:
  - busy is high from after edge N until after edge N+DEPTH-1, i.e. DEPTH-1 cycles.
  - All registers read 0 after edge N+DEPTH-1.
- A write presented in the same cycle as clr_req (FSM in IDLE) commits at that edge; the clear then overwrites it.
- Reset mid-clear: the FSM is aborted immediately to IDLE and all registers are 0.
- Debug: with dbg_en held high from reset, dbg_addr steps 0→1 at edge DBG_DIV, 1→2 at edge 2·DBG_DIV, and so on.

## Configuration
- RF_BYPASS_EN defined:
  - rdN forwards the in-flight write data when a write to raN is enabled in the same cycle (raN≠0, busy=0).
  - Port 1 has priority over port 0 when both match.
  - dbg_data is not bypassed.
- RF_BYPASS_EN undefined: rdN always returns stored contents; new data appears the cycle after the write.

## Test plan
- Reset, then we0=1 wa0=3 wd0=0xDEADBEEF; next cycle ra0=3 → rd0=0xDEADBEEF, with ra1=0 → rd1=0.
- we0/we1 both write address 7 with 0x11 and 0x22 → rd0 at ra0=7 reads 0x22.
- we1=1 wa1=0 wd1=0xFFFFFFFF → rd0 at ra0=0 stays 0.
- Bulk clear:
  - Fill registers 1..31 with nonzero data, pulse clr_req; busy is high for exactly 31 cycles.
  - A we0 issued mid-clear to address 5 with 0xAB is dropped.
  - After the clear, every register reads 0.
- With RF_BYPASS_EN defined: we0=1 wa0=9 wd0=0x55 and ra1=9 in the same cycle → rd1=0x55 in that cycle. Without the macro → rd1 holds the old value until the next cycle.
- DBG_DIV=4, dbg_en=1 after reset: dbg_addr is 0,1,2 at cycles 0,4,8.
  - Deassert dbg_en at cycle 9 → dbg_addr holds 2.
  - Assert rstn=0 mid-clear → busy=0 immediately and all reads are 0.
